// File: rtl/vending_controller.sv
// Coin-operated vending controller.
// Collects coins into a balance register, dispenses a product when the
// balance covers its price, and pays out any remainder as a stream of
// fixed-value change coins.
//
// Ports:
//   clk          - single clock, all state on rising edge
//   reset        - synchronous, active-high reset
//   coin_valid   - coin offered this cycle
//   coin_value   - value of offered coin (COIN_W bits)
//   coin_ready   - coin accepted when coin_valid && coin_ready
//   sel_valid    - single-cycle product selection request
//   sel          - selected product index
//   cancel       - request refund of current balance
//   vend         - one-cycle pulse, product dispensed
//   vend_prod    - index of dispensed product, valid while vend
//   sel_err      - one-cycle pulse, selection refused
//   change_valid - one change coin of CHANGE_COIN offered
//   change_ack   - change coin taken when change_valid && change_ack
//   balance      - current credit, registered
module vending_controller #(
  parameter int unsigned COIN_W      = 5,
  parameter int unsigned BAL_W       = 7,
  parameter int unsigned N_PROD      = 4,
  parameter logic [N_PROD*BAL_W-1:0] PRICES = {7'd15, 7'd20, 7'd25, 7'd40},
  parameter int unsigned CHANGE_COIN = 5,
  localparam int unsigned SEL_W      = $clog2(N_PROD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              coin_valid,
  input  logic [COIN_W-1:0] coin_value,
  output logic              coin_ready,
  input  logic              sel_valid,
  input  logic [SEL_W-1:0]  sel,
  input  logic              cancel,
  output logic              vend,
  output logic [SEL_W-1:0]  vend_prod,
  output logic              sel_err,
  output logic              change_valid,
  input  logic              change_ack,
  output logic [BAL_W-1:0]  balance
);

  // Highest balance that can still absorb the largest possible coin.
  localparam logic [BAL_W-1:0] COIN_LIMIT =
    BAL_W'((2 ** BAL_W - 1) - (2 ** COIN_W - 1));
  localparam logic [BAL_W-1:0] CHANGE_VAL = BAL_W'(CHANGE_COIN);

  typedef enum logic [1:0] {StIdle, StCollect, StVend, StChange} state_e;

  state_e             state_q;
  logic [BAL_W-1:0]   balance_q;
  logic               vend_q;
  logic [SEL_W-1:0]   vend_prod_q;
  logic               sel_err_q;
  logic               change_valid_q;

  logic               coin_acc;
  logic [BAL_W-1:0]   bal_plus;
  logic [BAL_W-1:0]   bal_minus_change;
  logic [31:0]        sel_ext;
  logic               sel_in_range;
  logic [BAL_W-1:0]   price;

  assign coin_ready = ((state_q == StIdle) || (state_q == StCollect)) &&
                      (balance_q <= COIN_LIMIT);
  assign coin_acc   = coin_valid && coin_ready;
  assign bal_plus   = balance_q +
                      (coin_acc ? {{(BAL_W-COIN_W){1'b0}}, coin_value} : '0);
  assign bal_minus_change = balance_q - CHANGE_VAL;

  // Widened so the range check stays meaningful when N_PROD is not a power of two.
  assign sel_ext      = 32'(sel);
  assign sel_in_range = sel_ext < N_PROD;

  always_comb begin
    price = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (sel_ext == 32'(i)) price = PRICES[i*BAL_W +: BAL_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      balance_q      <= '0;
      vend_q         <= 1'b0;
      vend_prod_q    <= '0;
      sel_err_q      <= 1'b0;
      change_valid_q <= 1'b0;
    end else begin
      vend_q    <= 1'b0;
      sel_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          balance_q <= bal_plus;
          if (coin_acc && (coin_value != '0)) state_q <= StCollect;
          if (sel_valid) sel_err_q <= 1'b1;
        end
        StCollect: begin
          if (cancel) begin
            if (bal_plus >= CHANGE_VAL) begin
              balance_q      <= bal_plus;
              change_valid_q <= 1'b1;
              state_q        <= StChange;
            end else begin
              balance_q <= '0;
              state_q   <= StIdle;
            end
          end else if (sel_valid && sel_in_range && (balance_q >= price)) begin
            // Price is judged against the pre-coin balance; a same-cycle coin still counts.
            balance_q   <= bal_plus - price;
            vend_prod_q <= sel;
            vend_q      <= 1'b1;
            state_q     <= StVend;
          end else begin
            balance_q <= bal_plus;
            if (sel_valid) sel_err_q <= 1'b1;
          end
        end
        StVend: begin
          if (balance_q >= CHANGE_VAL) begin
            change_valid_q <= 1'b1;
            state_q        <= StChange;
          end else begin
            balance_q <= '0;
            state_q   <= StIdle;
          end
        end
        StChange: begin
          if (change_ack) begin
            if (bal_minus_change < CHANGE_VAL) begin
              // Residue smaller than one change coin is forfeited.
              balance_q      <= '0;
              change_valid_q <= 1'b0;
              state_q        <= StIdle;
            end else begin
              balance_q <= bal_minus_change;
            end
          end
        end
      endcase
    end
  end

  assign vend         = vend_q;
  assign vend_prod    = vend_prod_q;
  assign sel_err      = sel_err_q;
  assign change_valid = change_valid_q;
  assign balance      = balance_q;

endmodule
